// File: rtl/fp_itof16_seq_pkg.sv
// rtl/fp_itof16_seq_pkg.sv - shared FP16 types, rounding modes and constants
package fp16Pkg;

  typedef logic [15:0] FP16;

  localparam int EMSB = 14;
  localparam int FMSB = 9;
  localparam int BIAS = 15;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rm_e;

  localparam FP16 FP16_PINF = 16'h7C00;
  localparam FP16 FP16_MAXF = 16'h7BFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2
  } itof_state_e;

endpackage

// File: rtl/fp_round16.sv
// rtl/fp_round16.sv - combinational FP16 rounder from a normalised magnitude
module fp_round16
  import fp16Pkg::*;
#(
  parameter int EW = 7
) (
  input  logic          sign,
  input  logic [EW-1:0] e,
  input  logic [11:0]   top,
  input  logic          sticky,
  input  logic [2:0]    rm,
  output FP16           o,
  output logic          overflow,
  output logic          inexact
);

  logic [9:0]  frac;
  logic        guard;
  logic        inc;
  logic [10:0] sum;
  logic [EW:0] biased;

  always_comb begin
    frac  = top[10:1];
    guard = top[0];
    case (rm)
      RTZ:     inc = 1'b0;
      RDN:     inc = sign & (guard | sticky);
      RUP:     inc = ~sign & (guard | sticky);
      RMM:     inc = guard;
      default: inc = guard & (sticky | frac[0]);
    endcase
    sum      = {1'b0, frac} + {10'd0, inc};
    // A carry out of the fraction bumps the exponent; the fraction wraps to zero.
    biased   = {1'b0, e} + (EW+1)'(sum[10]) + (EW+1)'(BIAS);
    overflow = biased >= (EW+1)'(31);
    inexact  = guard | sticky | overflow;
    o        = {sign, biased[4:0], sum[9:0]};
    if (overflow) begin
      case (rm)
        RTZ:     o = FP16_MAXF | {sign, 15'd0};
        RDN:     o = sign ? (FP16_PINF | 16'h8000) : FP16_MAXF;
        RUP:     o = sign ? (FP16_MAXF | 16'h8000) : FP16_PINF;
        default: o = FP16_PINF | {sign, 15'd0};
      endcase
    end
    // No hidden bit means the operand was zero: always +0, exact.
    if (!top[11]) begin
      o        = 16'h0000;
      overflow = 1'b0;
      inexact  = 1'b0;
    end
  end

endmodule

// File: rtl/fp_itof16_seq.sv
// rtl/fp_itof16_seq.sv - sequential signed integer to FP16 converter
module fp_itof16_seq
  import fp16Pkg::*;
#(
  parameter int WID = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic           ld,
  input  logic [WID-1:0] i,
  input  logic [2:0]     rm,
  output FP16            o,
  output logic           done,
  output logic           busy,
  output logic           overflow,
  output logic           inexact
);

  localparam int EW = 7;

  itof_state_e    state, state_nx;
  logic           sign_q;
  logic [WID-1:0] mag_q;
  logic [EW-1:0]  e_q;
  logic [2:0]     rm_q;
  logic           sticky;
  FP16            rnd_o;
  logic           rnd_ovf;
  logic           rnd_inx;

  if (WID > 12) begin : g_sticky
    assign sticky = |mag_q[WID-13:0];
  end else begin : g_nosticky
    assign sticky = 1'b0;
  end

  fp_round16 #(.EW(EW)) u_round (
    .sign     (sign_q),
    .e        (e_q),
    .top      (mag_q[WID-1 -: 12]),
    .sticky   (sticky),
    .rm       (rm_q),
    .o        (rnd_o),
    .overflow (rnd_ovf),
    .inexact  (rnd_inx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else if (ce) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    case (state)
      IDLE:    if (ld) state_nx = (i == '0) ? ROUND : NORM;
      NORM:    if (mag_q[WID-1]) state_nx = ROUND;
      ROUND:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Zero skips normalisation; its all-zero magnitude makes the rounder emit +0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q   <= 1'b0;
      mag_q    <= '0;
      e_q      <= '0;
      rm_q     <= '0;
      o        <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      inexact  <= 1'b0;
    end else if (ce) begin
      done <= 1'b0;
      case (state)
        IDLE: if (ld) begin
          sign_q <= i[WID-1];
          mag_q  <= i[WID-1] ? -i : i;
          e_q    <= EW'(WID-1);
          rm_q   <= rm;
        end
        NORM: if (!mag_q[WID-1]) begin
          mag_q <= mag_q << 1;
          e_q   <= e_q - 1'b1;
        end
        ROUND: begin
          done     <= 1'b1;
          o        <= rnd_o;
          overflow <= rnd_ovf;
          inexact  <= rnd_inx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_itof16_seq.sv
// tb/tb_fp_itof16_seq.sv - scoreboard bench for the integer to FP16 converter
module tb_fp_itof16_seq;
  import fp16Pkg::*;

  localparam int WID = 32;

  logic        clk = 1'b0;
  logic        rst, ce, ld;
  logic [31:0] i;
  logic [2:0]  rm;
  FP16         o;
  logic        done, busy, overflow, inexact;

  int total = 0;
  int bad = 0;
  int ce_edges = 0;
  bit en;

  typedef struct {
    logic [15:0] o;
    logic        ov;
    logic        inx;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] v;
    logic [2:0]  m;
    logic [15:0] o;
    logic        ov;
    logic        inx;
  } dir_t;

  exp_t q[$];

  always #5 clk = ~clk;

  fp_itof16_seq #(.WID(WID)) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .ld       (ld),
    .i        (i),
    .rm       (rm),
    .o        (o),
    .done     (done),
    .busy     (busy),
    .overflow (overflow),
    .inexact  (inexact)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, want);
    end
  endtask

  // Exact integer value rounded by comparing the discarded remainder to half an ulp.
  function automatic exp_t model(input logic [31:0] v, input logic [2:0] m);
    exp_t   r;
    longint mag, lo, rem, half;
    bit     s, up;
    int     e, be;
    s     = v[31];
    mag   = s ? -longint'($signed(v)) : longint'($signed(v));
    r.o   = 16'h0000;
    r.ov  = 1'b0;
    r.inx = 1'b0;
    r.acc = 0;
    if (mag == 0) begin
      r.lat = 2;
      return r;
    end
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    r.lat = (WID - 1 - e) + 3;
    if (e <= 10) begin
      lo = mag << (10 - e); rem = 0; half = 1;
    end else begin
      lo   = mag >> (e - 10);
      rem  = mag - (lo << (e - 10));
      half = longint'(1) << (e - 11);
    end
    case (m)
      3'd1:    up = 1'b0;
      3'd2:    up = s && rem != 0;
      3'd3:    up = !s && rem != 0;
      3'd4:    up = rem >= half;
      default: up = rem > half || (rem == half && lo[0]);
    endcase
    lo = lo + longint'(up);
    if (lo == 2048) begin lo = 1024; e++; end
    be    = e + 15;
    r.inx = rem != 0;
    if (be >= 31) begin
      r.ov  = 1'b1;
      r.inx = 1'b1;
      case (m)
        3'd1:    r.o = s ? 16'hFBFF : 16'h7BFF;
        3'd2:    r.o = s ? 16'hFC00 : 16'h7BFF;
        3'd3:    r.o = s ? 16'hFBFF : 16'h7C00;
        default: r.o = s ? 16'hFC00 : 16'h7C00;
      endcase
    end else begin
      r.o = {s, 5'(be), 10'(lo - 1024)};
    end
    return r;
  endfunction

  task automatic issue(input logic [31:0] v, input logic [2:0] m, input bit rand_ce,
                       input bit use_lit, input logic [15:0] lo, input logic lov, input logic linx);
    exp_t x;
    bit   acc = 1'b0;
    for (int n = 0; n < 400 && !acc; n++) begin
      @(negedge clk);
      ce = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ce && !busy) begin
        ld = 1'b1; i = v; rm = m;
        x = model(v, m);
        if (use_lit) begin x.o = lo; x.ov = lov; x.inx = linx; end
        x.acc = ce_edges + 1;
        q.push_back(x);
        acc = 1'b1;
      end else begin
        ld = 1'($urandom_range(0, 1)); i = $urandom; rm = 3'($urandom);
      end
    end
    if (!acc) begin
      total++; bad++;
      $display("FAIL issue_timeout: got busy=%0b want accepted", busy);
    end else begin
      @(negedge clk);
      ld = 1'b0;
      chk("busy_after_ld", 32'(busy), 32'd1);
      ce = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic drain(input bit rand_ce);
    bit ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      ce = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
      ld = 1'b0;
      if (q.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL drain_timeout: got pending=%0d want 0", q.size());
    end
  endtask

  always begin
    exp_t x;
    @(posedge clk);
    en = ce && !rst;
    if (en) ce_edges++;
    @(negedge clk);
    if (en && done === 1'b1) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got o=0x%0h want no completion", o);
      end else begin
        x = q.pop_front();
        chk("o", 32'(o), 32'(x.o));
        chk("overflow", 32'(overflow), 32'(x.ov));
        chk("inexact", 32'(inexact), 32'(x.inx));
        chk("latency", 32'(ce_edges - x.acc + 1), 32'(x.lat));
      end
    end
  end

  dir_t dir[12] = '{
    '{32'd1,          3'd0, 16'h3C00, 1'b0, 1'b0},
    '{32'hFFFFFFFE,   3'd0, 16'hC000, 1'b0, 1'b0},
    '{32'd0,          3'd0, 16'h0000, 1'b0, 1'b0},
    '{32'd2049,       3'd0, 16'h6800, 1'b0, 1'b1},
    '{32'd2049,       3'd3, 16'h6801, 1'b0, 1'b1},
    '{32'd2049,       3'd2, 16'h6800, 1'b0, 1'b1},
    '{32'hFFFFF7FF,   3'd2, 16'hE801, 1'b0, 1'b1},
    '{32'd65520,      3'd0, 16'h7C00, 1'b1, 1'b1},
    '{32'd65520,      3'd1, 16'h7BFF, 1'b0, 1'b1},
    '{32'd100000,     3'd1, 16'h7BFF, 1'b1, 1'b1},
    '{32'h80000000,   3'd3, 16'hFBFF, 1'b1, 1'b1},
    '{32'h80000000,   3'd2, 16'hFC00, 1'b1, 1'b1}
  };

  initial begin
    logic [31:0] v;
    rst = 1'b1; ce = 1'b0; ld = 1'b0; i = '0; rm = '0;
    repeat (3) @(negedge clk);
    chk("rst_o", 32'(o), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_inexact", 32'(inexact), 32'h0);
    rst = 1'b0;

    foreach (dir[k]) issue(dir[k].v, dir[k].m, 1'b0, 1'b1, dir[k].o, dir[k].ov, dir[k].inx);
    drain(1'b0);

    @(negedge clk);
    ce = 1'b1; ld = 1'b1; i = 32'd1; rm = 3'd0;
    @(negedge clk);
    ld = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_mid_norm", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_o", 32'(o), 32'h0);
    chk("abort_overflow", 32'(overflow), 32'h0);
    chk("abort_inexact", 32'(inexact), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    issue(32'd2049, 3'd3, 1'b0, 1'b1, 16'h6801, 1'b0, 1'b1);

    for (int n = 0; n < 200; n++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = -v;
      if ($urandom_range(0, 15) == 0) v = 32'h80000000;
      issue(v, 3'($urandom_range(0, 7)), 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    end
    drain(1'b1);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
